fifo_drain_ctrl: RTL and testbench

//  Read-side controller sitting directly downstream of the 8-entry x 12-bit lane FIFO.

---
 rtl/fifo_drain_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_drain_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the 8x12 lane FIFO.
// Define DRAIN_CNT_EN to build the forwarded-word counter.
module fifo_drain_ctrl #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic              fifo_error,
    input  logic [DATA_W-1:0] fifo_data_out,
    input  logic              dn_almost_full,
    input  logic              dn_full,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  drained_cnt,
    output logic              error_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rd_q;
    logic   busy;
    logic   go;

    assign busy = dn_almost_full | dn_full;
    assign go   = enable & !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Backpressure outranks the idle condition when both apply.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = busy ? STALL : ACTIVE;
                end
            end
            ACTIVE: begin
                fifo_rd_en = !fifo_empty & !busy;
                if (busy) begin
                    state_nxt = STALL;
                end else if (!go) begin
                    state_nxt = IDLE;
                end
            end
            STALL: begin
                if (!busy) begin
                    state_nxt = go ? ACTIVE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q      <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            error_out <= 1'b0;
        end else begin
            rd_q      <= fifo_rd_en;
            valid_out <= rd_q;
            if (rd_q) begin
                data_out <= fifo_data_out;
            end
            // A word landing on a full next stage is still presented.
            if (fifo_error || (rd_q && dn_full)) begin
                error_out <= 1'b1;
            end
        end
    end

`ifdef DRAIN_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drained_cnt <= '0;
        end else if (rd_q) begin
            drained_cnt <= drained_cnt + CNT_W'(1);
        end
    end
`else
    assign drained_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a small FIFO model.
// Expected counter values follow DRAIN_CNT_EN.
module tb_fifo_drain_ctrl;

    localparam int DW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          enable;
    logic          fifo_error;
    logic          dn_almost_full;
    logic          dn_full;
    logic          ext_mode;
    logic          ext_empty;
    logic [DW-1:0] ext_data;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;

    logic [DW-1:0] mem [0:31];
    int            wp = 0;
    int            rp = 0;
    logic [DW-1:0] mem_q = '0;

    logic          fifo_rd_en;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [15:0]   drained_cnt;
    logic          error_out;

    logic          rd4;
    logic [DW-1:0] data4;
    logic          valid4;
    logic [3:0]    cnt4;
    logic          err4;

    int n_tests = 0;
    int n_fail  = 0;

    assign fifo_empty    = ext_mode ? ext_empty : (wp == rp);
    assign fifo_data_out = ext_mode ? ext_data : mem_q;

    // FIFO read port: word appears one cycle after the pop
    always @(posedge clk) begin
        if (!ext_mode && fifo_rd_en) begin
            mem_q <= mem[rp % 32];
            rp    <= rp + 1;
        end
    end

    fifo_drain_ctrl #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error),
        .fifo_data_out(fifo_data_out),
        .dn_almost_full(dn_almost_full), .dn_full(dn_full),
        .fifo_rd_en(fifo_rd_en), .data_out(data_out),
        .valid_out(valid_out), .drained_cnt(drained_cnt),
        .error_out(error_out)
    );

    fifo_drain_ctrl #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error),
        .fifo_data_out(fifo_data_out),
        .dn_almost_full(dn_almost_full), .dn_full(dn_full),
        .fifo_rd_en(rd4), .data_out(data4),
        .valid_out(valid4), .drained_cnt(cnt4),
        .error_out(err4)
    );

    typedef struct {
        logic en;
        logic emp;
        logic af;
        logic full;
        logic exp_rd;
        logic exp_v;
    } vec_t;

    vec_t tbl [18];

    int            pops;
    int            vals;
    int            v_in_af;
    int            rd_in_af;
    int            pops_after_dis;
    int            first_rd;
    int            last_rd;
    int            first_v;
    logic [DW-1:0] got [0:31];

    function automatic int exp_cnt(input int n, input int w);
`ifdef DRAIN_CNT_EN
        return n % (1 << w);
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        enable         = 1'b0;
        fifo_error     = 1'b0;
        dn_almost_full = 1'b0;
        dn_full        = 1'b0;
        ext_mode       = 1'b0;
        ext_empty      = 1'b1;
        wp             = rp;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wp % 32] = v;
        wp++;
    endtask

    // Runs ncyc cycles from a negedge; optional flag window and disable.
    task automatic run(input int ncyc, input int af_pop, input int af_len,
                       input int dis_pop);
        int af_cnt;
        int dis_cyc;
        af_cnt = 0;
        dis_cyc = 0;
        pops = 0;
        vals = 0;
        v_in_af = 0;
        rd_in_af = 0;
        pops_after_dis = 0;
        first_rd = -1;
        last_rd = -1;
        first_v = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (af_pop > 0 && pops == af_pop && af_cnt < af_len) begin
                dn_almost_full = 1'b1;
                af_cnt++;
            end else begin
                dn_almost_full = 1'b0;
            end
            if (dis_pop > 0 && pops >= dis_pop) begin
                enable = 1'b0;
                dis_cyc++;
            end
            #1;
            if (fifo_rd_en) begin
                pops++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                if (dn_almost_full) rd_in_af++;
                if (dis_cyc > 1) pops_after_dis++;
            end
            if (valid_out) begin
                if (vals < 32) got[vals] = data_out;
                vals++;
                if (first_v < 0) first_v = c;
                if (dn_almost_full) v_in_af++;
            end
            @(negedge clk);
        end
        dn_almost_full = 1'b0;
    endtask

    function automatic vec_t mk(input logic en, input logic emp,
                                input logic af, input logic full,
                                input logic rd, input logic v);
        vec_t r;
        r.en = en;
        r.emp = emp;
        r.af = af;
        r.full = full;
        r.exp_rd = rd;
        r.exp_v = v;
        return r;
    endfunction

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 1, 0);
        tbl[5]  = mk(1, 0, 1, 0, 0, 1);
        tbl[6]  = mk(1, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 1, 0, 0);
        tbl[13] = mk(1, 0, 0, 1, 0, 0);
        tbl[14] = mk(1, 1, 0, 0, 0, 0);
        tbl[15] = mk(1, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 1, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 0, 0, 0, 0);

        // reset held with random inputs
        reset = 1'b0;
        ext_mode = 1'b1;
        enable = 1'b0;
        ext_empty = 1'b1;
        ext_data = '0;
        fifo_error = 1'b0;
        dn_almost_full = 1'b0;
        dn_full = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            enable         = 1'($urandom_range(0, 1));
            ext_empty      = 1'($urandom_range(0, 1));
            fifo_error     = 1'($urandom_range(0, 1));
            dn_almost_full = 1'($urandom_range(0, 1));
            dn_full        = 1'($urandom_range(0, 1));
            ext_data       = DW'($urandom);
            #1;
            chk("rst_rd_en", 32'(fifo_rd_en), 0);
            chk("rst_data", 32'(data_out), 0);
            chk("rst_valid", 32'(valid_out), 0);
            chk("rst_cnt", 32'(drained_cnt), 0);
            chk("rst_err", 32'(error_out), 0);
            @(negedge clk);
        end
        reset = 1'b1;
        enable = 1'b1;
        ext_empty = 1'b1;
        fifo_error = 1'b0;
        dn_almost_full = 1'b0;
        dn_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_rd_en", 32'(fifo_rd_en), 0);
            chk("idle_valid", 32'(valid_out), 0);
            @(negedge clk);
        end

        // FSM transition table
        do_reset();
        ext_mode = 1'b1;
        for (int i = 0; i < 18; i++) begin
            enable         = tbl[i].en;
            ext_empty      = tbl[i].emp;
            dn_almost_full = tbl[i].af;
            dn_full        = tbl[i].full;
            ext_data       = DW'(i);
            #1;
            chk($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en),
                32'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_valid", i), 32'(valid_out),
                32'(tbl[i].exp_v));
            chk($sformatf("vec%0d_err", i), 32'(error_out), 0);
            @(negedge clk);
        end

        // 8-word stream
        do_reset();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        enable = 1'b1;
        run(16, 0, 0, 0);
        chk("stream_pops", pops, 8);
        chk("stream_consec", last_rd - first_rd, 7);
        chk("stream_latency", first_v - first_rd, 2);
        chk("stream_vals", vals, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("stream_word%0d", i), 32'(got[i]), i + 1);
        chk("stream_cnt", 32'(drained_cnt), exp_cnt(8, 16));
        chk("stream_cnt4", 32'(cnt4), exp_cnt(8, 4));
        chk("stream_err", 32'(error_out), 0);

        // almost_full after third pop
        do_reset();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        enable = 1'b1;
        run(24, 3, 4, 0);
        chk("bp_rd_in_af", rd_in_af, 0);
        chk("bp_v_in_af", v_in_af, 2);
        chk("bp_pops", pops, 8);
        chk("bp_vals", vals, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("bp_word%0d", i), 32'(got[i]), i + 1);
        chk("bp_err", 32'(error_out), 0);

        // enable dropped mid-stream
        do_reset();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        enable = 1'b1;
        run(16, 0, 0, 3);
        chk("dis_pops_after", pops_after_dis, 0);
        chk("dis_pops", pops, 4);
        chk("dis_vals", vals, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("dis_word%0d", i), 32'(got[i]), i + 1);

        // sticky fifo_error
        do_reset();
        ext_mode = 1'b1;
        ext_empty = 1'b1;
        fifo_error = 1'b1;
        #1;
        chk("ferr_pre", 32'(error_out), 0);
        @(negedge clk);
        fifo_error = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("ferr_sticky%0d", i), 32'(error_out), 1);
            @(negedge clk);
        end
        do_reset();
        #1;
        chk("ferr_cleared", 32'(error_out), 0);

        // dn_full while a word is in flight
        @(negedge clk);
        push(12'h0a5);
        push(12'h05a);
        enable = 1'b1;
        @(negedge clk);
        #1;
        chk("full_pop", 32'(fifo_rd_en), 1);
        @(negedge clk);
        dn_full = 1'b1;
        #1;
        chk("full_err_pre", 32'(error_out), 0);
        @(negedge clk);
        #1;
        chk("full_valid", 32'(valid_out), 1);
        chk("full_data", 32'(data_out), 32'h0a5);
        chk("full_err", 32'(error_out), 1);
        @(negedge clk);
        dn_full = 1'b0;

        // counter wrap
        do_reset();
        for (int i = 0; i < 17; i++) push(DW'(12'h100 + i));
        enable = 1'b1;
        run(28, 0, 0, 0);
        chk("wrap_vals", vals, 17);
        chk("wrap_word16", 32'(got[16]), 32'h110);
        chk("wrap_cnt16", 32'(drained_cnt), exp_cnt(17, 16));
        chk("wrap_cnt4", 32'(cnt4), exp_cnt(17, 4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
